snn_timestep_sequencer: RTL and testbench

- Run controller for the 3x2 SNN grid. Sequences a CPU-programmed number of timesteps: waits for packet loading to end, then for the grid to drain and settle, then issues `tick`.
- Pulses `spike_en` to capture each timestep's spike vector and raises `complete` after the last capture.
- Sits between the packet loader / CPU control registers and the grid. Adds a tick budget, drain watchdog and abort over plain tick generation.

---
 rtl/snn_seq_pkg.sv | 21 ++
 rtl/idle_qualifier.sv | 41 ++++
 rtl/snn_timestep_sequencer.sv | 116 +++++++++++
 tb/tb_snn_timestep_sequencer.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/snn_seq_pkg.sv
`default_nettype none
// snn_seq_pkg: shared state encoding and default parameters for the SNN timestep sequencer.
package snn_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_WAIT_LOAD = 3'd1,
    ST_DRAIN     = 3'd2,
    ST_SETTLE    = 3'd3,
    ST_TICK      = 3'd4,
    ST_CAPTURE   = 3'd5,
    ST_DONE      = 3'd6,
    ST_ERROR     = 3'd7
  } seq_state_t;

  localparam logic [2:0] GRID_IDLE_DEFAULT  = 3'd0;
  localparam int         SETTLE_CYC_DEFAULT = 4;
  localparam int         TO_W_DEFAULT       = 16;

endpackage
`default_nettype wire

// File: rtl/idle_qualifier.sv
`default_nettype none
// idle_qualifier: counts consecutive idle cycles (settle) and total drain/settle cycles (watchdog).
module idle_qualifier
  import snn_seq_pkg::*;
#(
  parameter int SETTLE_CYC = SETTLE_CYC_DEFAULT,
  parameter int TO_W       = TO_W_DEFAULT
) (
  input  logic clk,
  input  logic reset_n,
  input  logic idle_cond,
  input  logic count_en,
  input  logic clear,
  output logic settled,
  output logic timeout
);

  localparam int              SC_W       = 4;
  localparam logic [SC_W-1:0] SETTLE_TGT = SC_W'(SETTLE_CYC);
  // Last count value before the watchdog hits 2^TO_W-1 elapsed cycles.
  localparam logic [TO_W-1:0] WD_LAST    = {{(TO_W-1){1'b1}}, 1'b0};

  logic [SC_W-1:0] settle_cnt;
  logic [TO_W-1:0] wd_cnt;

  always_ff @(posedge clk) begin
    if (!reset_n || clear) begin
      settle_cnt <= '0;
      wd_cnt     <= '0;
    end else if (count_en) begin
      // A busy cycle restarts the settle window; an idle one extends it.
      settle_cnt <= idle_cond ? settle_cnt + 1'b1 : '0;
      wd_cnt     <= wd_cnt + 1'b1;
    end
  end

  assign settled = count_en & idle_cond & (settle_cnt == SETTLE_TGT);
  assign timeout = count_en & (wd_cnt == WD_LAST);

endmodule
`default_nettype wire

// File: rtl/snn_timestep_sequencer.sv
`default_nettype none
// snn_timestep_sequencer: issues a programmed number of grid timesteps, each after the
// grid has drained and settled, with per-step spike capture, drain watchdog and abort.
module snn_timestep_sequencer
  import snn_seq_pkg::*;
#(
  parameter int         TICK_W     = 16,
  parameter int         SETTLE_CYC = SETTLE_CYC_DEFAULT,
  parameter int         TO_W       = TO_W_DEFAULT,
  parameter logic [2:0] GRID_IDLE  = GRID_IDLE_DEFAULT
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              abort,
  input  logic [TICK_W-1:0] num_ticks,
  input  logic              load_end,
  input  logic              input_buffer_empty,
  input  logic              forward_north_local_buffer_empty_all,
  input  logic [2:0]        grid_state,
  output logic              tick,
  output logic              spike_en,
  output logic [TICK_W-1:0] tick_count,
  output logic              busy,
  output logic              complete,
  output logic              timeout_err,
  output logic [2:0]        state
);

  seq_state_t        cur_state;
  seq_state_t        nxt_state;
  logic [TICK_W-1:0] budget;
  logic              idle_cond;
  logic              count_en;
  logic              settled;
  logic              timeout;
  logic              launch;

  assign idle_cond = input_buffer_empty & forward_north_local_buffer_empty_all &
                     (grid_state == GRID_IDLE);
  assign count_en  = (cur_state == ST_DRAIN) || (cur_state == ST_SETTLE);

  idle_qualifier #(
    .SETTLE_CYC (SETTLE_CYC),
    .TO_W       (TO_W)
  ) u_idle_qualifier (
    .clk       (clk),
    .reset_n   (reset_n),
    .idle_cond (idle_cond),
    .count_en  (count_en),
    .clear     (!count_en),
    .settled   (settled),
    .timeout   (timeout)
  );

  always_comb begin
    nxt_state = cur_state;
    launch    = 1'b0;
    if (abort) begin
      nxt_state = ST_IDLE;
    end else begin
      case (cur_state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            launch    = 1'b1;
            nxt_state = (num_ticks == '0) ? ST_DONE : ST_WAIT_LOAD;
          end
        end
        ST_WAIT_LOAD: if (load_end) nxt_state = ST_DRAIN;
        ST_DRAIN: begin
          if (timeout)        nxt_state = ST_ERROR;
          else if (idle_cond) nxt_state = ST_SETTLE;
        end
        ST_SETTLE: begin
          if (timeout)         nxt_state = ST_ERROR;
          else if (!idle_cond) nxt_state = ST_DRAIN;
          else if (settled)    nxt_state = ST_CAPTURE;
        end
        // The first capture of a run precedes any tick and only primes the loop.
        ST_CAPTURE: nxt_state = (tick_count == budget) ? ST_DONE : ST_TICK;
        ST_TICK:    nxt_state = ST_DRAIN;
        ST_ERROR:   nxt_state = ST_ERROR;
        default:    nxt_state = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cur_state   <= ST_IDLE;
      tick        <= 1'b0;
      spike_en    <= 1'b0;
      tick_count  <= '0;
      budget      <= '0;
      complete    <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      cur_state   <= nxt_state;
      tick        <= (nxt_state == ST_TICK);
      spike_en    <= (nxt_state == ST_CAPTURE) && (tick_count != '0);
      complete    <= (nxt_state == ST_DONE);
      timeout_err <= (nxt_state == ST_ERROR);
      if (launch) begin
        budget     <= num_ticks;
        tick_count <= '0;
      end else if ((cur_state == ST_TICK) && (tick_count != budget)) begin
        tick_count <= tick_count + 1'b1;
      end
    end
  end

  assign state = cur_state;
  assign busy  = !((cur_state == ST_IDLE) || (cur_state == ST_DONE) || (cur_state == ST_ERROR));

endmodule
`default_nettype wire

// File: tb/tb_snn_timestep_sequencer.sv
`default_nettype none
// tb_snn_timestep_sequencer: table-driven runs plus corner sequences, with a tick/spike scoreboard.
module tb_snn_timestep_sequencer;
  import snn_seq_pkg::*;

  localparam int TICK_W     = 16;
  localparam int SETTLE_CYC = 4;
  localparam int TO_W       = 4;
  localparam int GAP_TT     = SETTLE_CYC + 3;
  localparam int GAP_TS     = SETTLE_CYC + 2;

  typedef struct {
    int         num;
    int         load_delay;
    logic [2:0] exp_state1;
    int         exp_tc;
    logic [2:0] exp_state_end;
  } vec_t;

  typedef struct {
    int tc;
    int gap;
  } ev_t;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              start = 1'b0;
  logic              abort = 1'b0;
  logic [TICK_W-1:0] num_ticks = '0;
  logic              load_end = 1'b0;
  logic              input_buffer_empty = 1'b1;
  logic              fwd_empty = 1'b1;
  logic [2:0]        grid_state = 3'd0;
  logic              tick;
  logic              spike_en;
  logic [TICK_W-1:0] tick_count;
  logic              busy;
  logic              complete;
  logic              timeout_err;
  logic [2:0]        state;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   last_tick = 0;
  int   n_ticks = 0;
  int   n_spikes = 0;
  ev_t  tick_q[$];
  ev_t  spike_q[$];
  vec_t vecs[5];

  always #5 clk = ~clk;

  snn_timestep_sequencer #(
    .TICK_W     (TICK_W),
    .SETTLE_CYC (SETTLE_CYC),
    .TO_W       (TO_W),
    .GRID_IDLE  (3'd0)
  ) dut (
    .clk                                  (clk),
    .reset_n                              (reset_n),
    .start                                (start),
    .abort                                (abort),
    .num_ticks                            (num_ticks),
    .load_end                             (load_end),
    .input_buffer_empty                   (input_buffer_empty),
    .forward_north_local_buffer_empty_all (fwd_empty),
    .grid_state                           (grid_state),
    .tick                                 (tick),
    .spike_en                             (spike_en),
    .tick_count                           (tick_count),
    .busy                                 (busy),
    .complete                             (complete),
    .timeout_err                          (timeout_err),
    .state                                (state)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push_ev(input bit is_tick, input int tc, input int gap);
    ev_t e;
    e.tc  = tc;
    e.gap = gap;
    if (is_tick) tick_q.push_back(e);
    else         spike_q.push_back(e);
  endtask

  // Advance to the next falling edge and score any tick/spike pulse seen there.
  task automatic step();
    ev_t e;
    @(negedge clk);
    cyc++;
    if (tick && spike_en) begin
      checks++;
      errors++;
      $display("FAIL tick_spike_overlap: both asserted at cycle %0d", cyc);
    end
    if (tick) begin
      n_ticks++;
      if (tick_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_tick: tick_count=%0d with no tick expected", tick_count);
      end else begin
        e = tick_q.pop_front();
        chk("tick_count_at_tick", 32'(tick_count), e.tc);
        if (e.gap != 0) chk("tick_spacing", cyc - last_tick, e.gap);
      end
      last_tick = cyc;
    end
    if (spike_en) begin
      n_spikes++;
      if (spike_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_spike_en: tick_count=%0d with no capture expected", tick_count);
      end else begin
        e = spike_q.pop_front();
        chk("tick_count_at_spike", 32'(tick_count), e.tc);
        chk("spike_after_tick", cyc - last_tick, e.gap);
      end
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_tick"},        tick, 0);
    chk({tag, "_spike_en"},    spike_en, 0);
    chk({tag, "_tick_count"},  32'(tick_count), 0);
    chk({tag, "_complete"},    complete, 0);
    chk({tag, "_timeout_err"}, timeout_err, 0);
    chk({tag, "_busy"},        busy, 0);
    chk({tag, "_state"},       state, ST_IDLE);
  endtask

  task automatic wait_end(input string tag);
    int k;
    k = 0;
    while (!complete && state != ST_ERROR && k < 400) begin
      step();
      k++;
    end
    if (k >= 400) begin
      checks++;
      errors++;
      $display("FAIL %s_wait_complete: not complete after %0d cycles, state=%0d", tag, k, state);
    end
  endtask

  task automatic run_vec(input vec_t v);
    int t0;
    int s0;
    t0 = n_ticks;
    s0 = n_spikes;
    for (int i = 0; i < v.num; i++) begin
      push_ev(1'b1, i, (i == 0) ? 0 : GAP_TT);
      push_ev(1'b0, i + 1, GAP_TS);
    end
    start     = 1'b1;
    num_ticks = TICK_W'(v.num);
    load_end  = (v.load_delay == 0);
    step();
    start = 1'b0;
    chk("state_after_start",      state, v.exp_state1);
    chk("complete_after_start",   complete, (v.exp_state1 == ST_DONE));
    chk("tick_count_after_start", 32'(tick_count), 0);
    if (v.load_delay > 0) begin
      repeat (v.load_delay) step();
      chk("held_in_wait_load", state, ST_WAIT_LOAD);
      load_end = 1'b1;
    end
    wait_end("run");
    chk("final_tick_count", 32'(tick_count), v.exp_tc);
    chk("final_state",      state, v.exp_state_end);
    chk("final_complete",   complete, 1);
    chk("final_busy",       busy, 0);
    chk("final_timeout",    timeout_err, 0);
    chk("ticks_in_run",     n_ticks - t0, v.num);
    chk("spikes_in_run",    n_spikes - s0, v.num);
    chk("tick_q_drained",   tick_q.size(), 0);
    chk("spike_q_drained",  spike_q.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, errors so far %0d", errors);
    $fatal(1, "global timeout");
  end

  initial begin
    int   k;
    int   t0;
    vec_t v;

    vecs[0] = '{num: 3, load_delay: 0, exp_state1: ST_WAIT_LOAD, exp_tc: 3, exp_state_end: ST_DONE};
    vecs[1] = '{num: 1, load_delay: 2, exp_state1: ST_WAIT_LOAD, exp_tc: 1, exp_state_end: ST_DONE};
    vecs[2] = '{num: 0, load_delay: 0, exp_state1: ST_DONE,      exp_tc: 0, exp_state_end: ST_DONE};
    vecs[3] = '{num: 4, load_delay: 3, exp_state1: ST_WAIT_LOAD, exp_tc: 4, exp_state_end: ST_DONE};
    vecs[4] = '{num: 2, load_delay: 1, exp_state1: ST_WAIT_LOAD, exp_tc: 2, exp_state_end: ST_DONE};

    repeat (3) step();
    reset_n = 1'b1;
    chk_reset_vals("reset");

    for (int i = 0; i < 5; i++) run_vec(vecs[i]);

    // Settle window broken by one busy cycle while settle count is 3.
    push_ev(1'b1, 0, 0);
    push_ev(1'b1, 1, GAP_TT + 4);
    push_ev(1'b0, 1, GAP_TS + 4);
    push_ev(1'b0, 2, GAP_TS);
    start     = 1'b1;
    num_ticks = TICK_W'(2);
    load_end  = 1'b1;
    step();
    start = 1'b0;
    k = 0;
    while (!tick && k < 100) begin
      step();
      k++;
    end
    chk("break_first_tick_seen", tick, 1);
    repeat (4) step();
    chk("state_before_break", state, ST_SETTLE);
    grid_state = 3'd2;
    step();
    grid_state = 3'd0;
    chk("state_after_break", state, ST_DRAIN);
    wait_end("break");
    chk("break_final_tc",    32'(tick_count), 2);
    chk("break_tick_q",      tick_q.size(), 0);
    chk("break_spike_q",     spike_q.size(), 0);

    // Drain never completes: watchdog must trip.
    input_buffer_empty = 1'b0;
    start     = 1'b1;
    num_ticks = TICK_W'(2);
    step();
    start = 1'b0;
    k = 1;
    while (state != ST_ERROR && k < 100) begin
      step();
      k++;
    end
    chk("watchdog_latency",     k, 2 + (2 ** TO_W - 1));
    chk("watchdog_timeout_err", timeout_err, 1);
    chk("watchdog_busy",        busy, 0);
    chk("watchdog_complete",    complete, 0);
    chk("watchdog_tick_count",  32'(tick_count), 0);
    start = 1'b1;
    step();
    start = 1'b0;
    chk("error_ignores_start",  state, ST_ERROR);
    chk("error_sticky",         timeout_err, 1);
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("abort_error_state",    state, ST_IDLE);
    chk("abort_error_timeout",  timeout_err, 0);
    input_buffer_empty = 1'b1;

    // Abort on the cycle that would enter TICK for the third step.
    t0 = n_ticks;
    push_ev(1'b1, 0, 0);
    push_ev(1'b1, 1, GAP_TT);
    push_ev(1'b0, 1, GAP_TS);
    push_ev(1'b0, 2, GAP_TS);
    start     = 1'b1;
    num_ticks = TICK_W'(5);
    step();
    start = 1'b0;
    k = 0;
    while (!(state == ST_CAPTURE && tick_count == TICK_W'(2)) && k < 200) begin
      step();
      k++;
    end
    chk("abort_reached_capture", state, ST_CAPTURE);
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("abort_tick",       tick, 0);
    chk("abort_state",      state, ST_IDLE);
    chk("abort_tick_count", 32'(tick_count), 2);
    chk("abort_complete",   complete, 0);
    chk("abort_busy",       busy, 0);
    repeat (10) step();
    chk("abort_ticks_total", n_ticks - t0, 2);
    chk("abort_tick_q",      tick_q.size(), 0);
    chk("abort_spike_q",     spike_q.size(), 0);

    // Reset asserted for one edge during SETTLE, then a fresh run.
    start     = 1'b1;
    num_ticks = TICK_W'(3);
    step();
    start = 1'b0;
    k = 0;
    while (state != ST_SETTLE && k < 50) begin
      step();
      k++;
    end
    chk("reached_settle", state, ST_SETTLE);
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    chk_reset_vals("midrun_reset");
    v = '{num: 2, load_delay: 0, exp_state1: ST_WAIT_LOAD, exp_tc: 2, exp_state_end: ST_DONE};
    run_vec(v);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
